multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
 - clk  in  1  clock
 - rst  in  1  synchronous active-high reset
 - opcode  in  6  instruction[31:26] from the instruction register
 - mem_ready  in  1  memory access completes this cycle
 - pc_write  out  1  unconditional PC load
 - pc_write_cond  out  1  PC load if ALU zero
 - i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
 - mem_read  out  1  memory read request
 - mem_write  out  1  memory write request
 - ir_write  out  1  instruction register load
 - reg_dst  out  1  write register select: 0 = rt, 1 = rd
 - mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR
 - reg_write  out  1  register file write enable
 - alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
 - alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
 - pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
 - alu_op  out  2  to the ALU controller: 00 = R-type (use func), 01 = ADD, 10 = SUB
 - illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
 - state  out  4  current state encoding, for debug

Function
REQ-003 The block SHALL be a Moore FSM with 12 states, encoded as follows: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
REQ-004 Every output not listed for a state SHALL be 0 in that state.
REQ-005 FETCH SHALL drive mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 01 and pc_src = 00; ir_write and pc_write SHALL be 1 only in a FETCH cycle where mem_ready = 1.
REQ-006 FETCH SHALL hold while mem_ready = 0 and SHALL move to DECODE on mem_ready = 1.
REQ-007 DECODE SHALL drive alu_src_a = 0, alu_src_b = 11 and alu_op = 01, and SHALL branch on opcode as follows:
 - 100011 (lw) or 101011 (sw) -> MEMADR
 - 000000 (R-type) -> EXECUTE
 - 000100 (beq) -> BRANCH
 - 001000 (addi) -> ADDIEX
 - 000010 (j) -> JUMP
 - any other value -> FETCH, with illegal_op = 1 for that DECODE cycle.
REQ-008 MEMADR SHALL drive alu_src_a = 1, alu_src_b = 10 and alu_op = 01, then go to MEMREAD for lw and MEMWRITE for sw; opcode SHALL be re-sampled in MEMADR.
REQ-009 MEMREAD SHALL drive i_or_d = 1 and mem_read = 1, holding until mem_ready = 1, then go to MEMWB.
REQ-010 MEMWB SHALL drive reg_dst = 0, mem_to_reg = 1 and reg_write = 1, then go to FETCH.
REQ-011 MEMWRITE SHALL drive i_or_d = 1 and mem_write = 1, holding until mem_ready = 1, then go to FETCH.
REQ-012 EXECUTE SHALL drive alu_src_a = 1, alu_src_b = 00 and alu_op = 00, then go to ALUWB.
REQ-013 ALUWB SHALL drive reg_dst = 1, mem_to_reg = 0 and reg_write = 1, then go to FETCH.
REQ-014 BRANCH SHALL drive alu_src_a = 1, alu_src_b = 00, alu_op = 10, pc_write_cond = 1 and pc_src = 01, then go to FETCH.
REQ-015 ADDIEX SHALL drive alu_src_a = 1, alu_src_b = 10 and alu_op = 01, then go to ADDIWB.
REQ-016 ADDIWB SHALL drive reg_dst = 0, mem_to_reg = 0 and reg_write = 1, then go to FETCH.
REQ-017 JUMP SHALL drive pc_write = 1 and pc_src = 10, then go to FETCH.
REQ-018 With mem_ready tied to 1, instruction latency from FETCH entry to the next FETCH entry SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-019 mem_read and mem_write SHALL never both be 1; reg_write, pc_write, ir_write and mem_write SHALL each be asserted for at most one cycle per instruction once mem_ready is seen.
REQ-020 Any unreachable state encoding (12-15) SHALL transition to FETCH on the next clock with all outputs 0.

Reset
REQ-021 When rst = 1 at a clock edge, state SHALL become FETCH regardless of the current state, including mid-wait in MEMREAD or MEMWRITE.
REQ-022 While rst = 1, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op) SHALL be forced to 0.
REQ-023 In the first cycle after rst is released, outputs SHALL equal the FETCH outputs.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
 - mem_ready = 1, opcode 000000 -> state sequence 0,1,6,7,0; alu_op = 00 in EXECUTE; reg_write = 1, reg_dst = 1 in ALUWB only.
 - mem_ready = 1, opcode 100011 -> states 0,1,2,3,4,0; mem_to_reg = 1, reg_write = 1 in MEMWB; i_or_d = 1 in MEMREAD.
 - opcode 101011 with mem_ready low for 3 cycles in MEMWRITE -> mem_write held for 4 cycles; exit to FETCH after mem_ready = 1; reg_write never asserted.
 - opcode 000100 -> BRANCH with alu_op = 10, pc_write_cond = 1, pc_src = 01; opcode 000010 -> JUMP with pc_write = 1, pc_src = 10.
 - opcode 111111 in DECODE -> illegal_op = 1 for exactly one cycle, next state FETCH.
 - rst asserted in MEMREAD during a stall -> next state FETCH; mem_read = 0 during the rst cycle.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_op, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style main controller for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Outputs decode from the state register; strobes are suppressed while rst is high.
module multicycle_control (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        ctl
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    if (ctl.mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (ctl.opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXECUTE;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_ADDI:      state_q <= ADDIEX;
                        OP_J:         state_q <= JUMP;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR:   state_q <= (ctl.opcode == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (ctl.mem_ready) state_q <= MEMWB;
                MEMWRITE: if (ctl.mem_ready) state_q <= FETCH;
                EXECUTE:  state_q <= ALUWB;
                BRANCH:   state_q <= FETCH;
                ADDIEX:   state_q <= ADDIWB;
                JUMP:     state_q <= FETCH;
                default:  state_q <= FETCH;  // MEMWB, ALUWB, ADDIWB and the unused codes 12-15
            endcase
        end
    end

    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pc_write          = 1'b0;
        pc_write_cond     = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        ir_write          = 1'b0;
        reg_write         = 1'b0;
        illegal_op        = 1'b0;
        ctl.i_or_d        = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = 2'b00;
        ctl.pc_src        = 2'b00;
        ctl.alu_op        = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read      = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = 2'b01;
                ir_write      = ctl.mem_ready;
                pc_write      = ctl.mem_ready;
            end
            DECODE: begin
                ctl.alu_src_b = 2'b11;
                ctl.alu_op    = 2'b01;
                case (ctl.opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                      illegal_op = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = 2'b01;
            end
            MEMREAD: begin
                ctl.i_or_d = 1'b1;
                mem_read   = 1'b1;
            end
            MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                reg_write      = 1'b1;
            end
            MEMWRITE: begin
                ctl.i_or_d = 1'b1;
                mem_write  = 1'b1;
            end
            EXECUTE: ctl.alu_src_a = 1'b1;
            ALUWB: begin
                ctl.reg_dst = 1'b1;
                reg_write   = 1'b1;
            end
            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
                ctl.pc_src    = 2'b01;
                pc_write_cond = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_write   = 1'b1;
                ctl.pc_src = 2'b10;
            end
            default: ;
        endcase
    end

    // Strobes are held low for the whole reset cycle, even mid-wait in a memory state.
    assign ctl.pc_write      = pc_write      & ~rst;
    assign ctl.pc_write_cond = pc_write_cond & ~rst;
    assign ctl.mem_read      = mem_read      & ~rst;
    assign ctl.mem_write     = mem_write     & ~rst;
    assign ctl.ir_write      = ir_write      & ~rst;
    assign ctl.reg_write     = reg_write     & ~rst;
    assign ctl.illegal_op    = illegal_op    & ~rst;
    assign ctl.state         = state_q;

endmodule
